// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one tx_serializer between NUM_REQ byte sources.
// Optional macro UART_TX_ARB_LOCK_EN adds req_lock so a requester can keep the grant across bytes.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   req_lock,
`endif
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 ser_req,
  input  logic                 ser_busy,
  output logic                 ser_data_avail,
  output logic [7:0]           ser_data,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 frame_done,
  output logic [1:0]           fsm_state
);

  // Handshakes: a requester's byte is taken on the cycle req_ack[i] is high (req_valid is
  // only looked at in IDLE); the serializer takes ser_data on a ser_req pulse while
  // ser_data_avail is high, and ser_busy high->low marks the end of that frame.
  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, LOAD = 2'd2, SEND = 2'd3} state_t;

  state_t            state, state_next;
  logic              grant_now;
  logic              rr_found;
  logic              lock_hit;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  rr_winner;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  winner;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int step);
    int sum;
    sum = (int'(base) + step) % NUM_REQ;
    return sum[IDX_W-1:0];
  endfunction

  // First pending requester after the last winner, wrapping.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr, k);
      if (!rr_found && req_valid[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic locked;
  assign lock_hit = locked && req_valid[grant_idx] && req_lock[grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
    end else if (grant_now) begin
      locked <= req_lock[winner];
    end else if (state == IDLE && !req_valid[grant_idx]) begin
      locked <= 1'b0;
    end
  end
`else
  assign lock_hit = 1'b0;
`endif

  assign winner = lock_hit ? grant_idx : rr_winner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_now  = 1'b0;
    case (state)
      IDLE: begin
        if (rr_found && !ser_busy) begin
          grant_now  = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER:   if (ser_req)   state_next = LOAD;
      LOAD:    if (ser_busy)  state_next = SEND;
      SEND:    if (!ser_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The granted byte is captured once so the requester may advance right after its ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= IDX_W'(NUM_REQ - 1);
      grant_idx  <= '0;
      ser_data   <= 8'h00;
      req_ack    <= '0;
      frame_done <= 1'b0;
    end else begin
      req_ack    <= '0;
      frame_done <= (state == SEND) && !ser_busy;
      if (grant_now) begin
        grant_idx <= winner;
        ser_data  <= req_data[8*winner +: 8];
        req_ack   <= NUM_REQ'(1) << winner;
        if (!lock_hit) rr_ptr <= winner;
      end
    end
  end

  assign grant_valid    = (state != IDLE);
  assign ser_data_avail = (state == OFFER);
  assign fsm_state      = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level arbiter model, serializer responder and
// byte scoreboard, plus directed scenarios with hand-computed grant orders and bytes.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic           ser_req;
  logic           ser_busy;
  logic           ser_data_avail;
  logic [7:0]     ser_data;
  logic           grant_valid;
  logic [1:0]     grant_idx;
  logic           frame_done;
  logic [1:0]     fsm_state;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
`ifdef UART_TX_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ack(req_ack), .ser_req(ser_req), .ser_busy(ser_busy),
    .ser_data_avail(ser_data_avail), .ser_data(ser_data), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .frame_done(frame_done), .fsm_state(fsm_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  src_q [N][$];
  logic [7:0]  exp_q [$];
  int          m_rr, m_last;
  bit          m_locked, m_inflight, m_accepted, m_started;
  logic [N-1:0] e_ack;
  logic        e_gv, e_avail, e_done;
  logic [1:0]  e_idx;
  logic [7:0]  e_data;
  logic [31:0] glog, blog;
  int          g_n, b_n, d_n;
  int          s_mode, s_delay, s_cnt;
  bit          s_busy, ser_hold, force_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] mask(input int bits);
    return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic model_reset();
    m_rr = N - 1; m_last = 0; m_locked = 0;
    m_inflight = 0; m_accepted = 0; m_started = 0;
    e_ack = '0; e_gv = 0; e_avail = 0; e_done = 0; e_idx = '0; e_data = 8'h00;
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    s_mode = 0; s_busy = 0; s_cnt = 0; s_delay = $urandom_range(0, 2);
    ser_req = 1'b0; ser_busy = force_busy; req_valid = '0; req_data = '0;
  endtask

  // ---------------- per-cycle: compare, serializer, requesters, model ----------------
  task automatic cycle();
    int w;
    @(negedge clk);
    if (rst) begin
      model_reset();
      return;
    end
    chk("req_ack", req_ack, e_ack);
    chk("grant_valid", grant_valid, e_gv);
    chk("ser_data_avail", ser_data_avail, e_avail);
    chk("grant_idx", grant_idx, e_idx);
    chk("ser_data", ser_data, e_data);
    chk("frame_done", frame_done, e_done);
    if (e_done) d_n++;

    ser_req = 1'b0;
    case (s_mode)
      0: if (ser_data_avail && !ser_hold) begin
           if (s_delay == 0) begin ser_req = 1'b1; s_mode = 1; end
           else s_delay--;
         end
      1: begin
           if (exp_q.size() == 0) begin
             n_cmp++; n_bad++;
             $display("FAIL sb_byte: got %0h expected none at %0t", ser_data, $time);
           end else chk("sb_byte", ser_data, exp_q.pop_front());
           blog = {blog[23:0], ser_data}; b_n++;
           s_busy = 1; s_cnt = 10; s_mode = 2;
         end
      default: begin
           s_cnt--;
           if (s_cnt == 0) begin s_busy = 0; s_mode = 0; s_delay = $urandom_range(0, 2); end
         end
    endcase
    ser_busy = s_busy | force_busy;

    for (int i = 0; i < N; i++) begin
      if (req_ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      req_valid[i] = (src_q[i].size() > 0);
      req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end

    // One transfer at a time: grant, serializer accept, frame start, frame end.
    e_ack = '0; e_done = 1'b0;
    if (!m_inflight) begin
`ifdef UART_TX_ARB_LOCK_EN
      if (m_locked && !req_valid[m_last]) m_locked = 0;
`endif
      if (req_valid != '0 && !ser_busy) begin
        w = rr_pick(req_valid, m_rr);
`ifdef UART_TX_ARB_LOCK_EN
        if (m_locked && req_valid[m_last] && req_lock[m_last]) w = m_last;
        else m_rr = w;
        m_locked = req_lock[w];
`else
        m_rr = w;
`endif
        m_last = w;
        e_ack = N'(1) << w; e_idx = w[1:0]; e_data = src_q[w][0];
        exp_q.push_back(e_data);
        glog = {glog[27:0], w[3:0]}; g_n++;
        m_inflight = 1; m_accepted = 0; m_started = 0;
      end
    end else if (!m_accepted) begin
      if (ser_req) m_accepted = 1;
    end else if (!m_started) begin
      if (ser_busy) m_started = 1;
    end else if (!ser_busy) begin
      m_inflight = 0; e_done = 1'b1;
    end
    e_gv = m_inflight;
    e_avail = m_inflight && !m_accepted;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drain(input string nm);
    int t = 0;
    while ((pending() != 0 || m_inflight) && t < 600) begin cycle(); t++; end
    if (t >= 600) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: pending=%0d in_flight=%0d required 0/0", nm, pending(), m_inflight);
    end
    repeat (2) cycle();
  endtask

  task automatic do_reset(input string nm);
    #3 rst = 1'b1;
    #1;
    chk({nm, "_rst_ack"}, req_ack, 0);
    chk({nm, "_rst_gv"}, grant_valid, 0);
    chk({nm, "_rst_avail"}, ser_data_avail, 0);
    chk({nm, "_rst_data"}, ser_data, 0);
    chk({nm, "_rst_idx"}, grant_idx, 0);
    chk({nm, "_rst_done"}, frame_done, 0);
    chk({nm, "_rst_state"}, fsm_state, 0);
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic phase_chk(input string nm, input int g0, input int b0, input int d0, input int ng,
                           input logic [31:0] gexp, input logic [31:0] bexp);
    chk({nm, "_grants"}, g_n - g0, ng);
    chk({nm, "_order"}, glog & mask(4 * ng), gexp);
    chk({nm, "_bytes_seen"}, b_n - b0, ng);
    chk({nm, "_bytes"}, blog & mask((ng > 4) ? 32 : 8 * ng), bexp);
    chk({nm, "_frames"}, d_n - d0, ng);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int g0, b0, d0, t;
    rst = 1'b1; ser_hold = 0; force_busy = 0;
    glog = '0; blog = '0; g_n = 0; b_n = 0; d_n = 0;
`ifdef UART_TX_ARB_LOCK_EN
    req_lock = '0;
`endif
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // 1: reset while offering, then a single A5 byte from requester 0
    ser_hold = 1;
    src_q[0].push_back(8'h3C);
    t = 0;
    while (!ser_data_avail && t < 20) begin cycle(); t++; end
    chk("t1_offer_seen", ser_data_avail, 1);
    do_reset("t1");
    ser_hold = 0;
    g0 = g_n; b0 = b_n; d0 = d_n;
    src_q[0].push_back(8'hA5);
    drain("t1");
    phase_chk("t1", g0, b0, d0, 1, 32'h0, 32'hA5);

    // 3: pointer at 3, then requesters 1 and 3 pending -> 1 then 3
    g0 = g_n; b0 = b_n; d0 = d_n;
    src_q[3].push_back(8'h33);
    drain("t3a");
    src_q[1].push_back(8'h31);
    src_q[3].push_back(8'h3B);
    drain("t3b");
    phase_chk("t3", g0, b0, d0, 3, 32'h313, 32'h33313B);

    // 2: all four pending -> 0,1,2,3,0
    g0 = g_n; b0 = b_n; d0 = d_n;
    src_q[0].push_back(8'h20); src_q[0].push_back(8'h24);
    src_q[1].push_back(8'h21);
    src_q[2].push_back(8'h22);
    src_q[3].push_back(8'h23);
    drain("t2");
    phase_chk("t2", g0, b0, d0, 5, 32'h01230, 32'h21222324);

    // 4: requester 1 advances 11 -> EE right after its ack
    g0 = g_n; b0 = b_n; d0 = d_n;
    src_q[1].push_back(8'h11); src_q[1].push_back(8'hEE);
    drain("t4");
    phase_chk("t4", g0, b0, d0, 2, 32'h11, 32'h11EE);

    // 5: foreign frame holds ser_busy high in IDLE
    g0 = g_n; b0 = b_n; d0 = d_n;
    force_busy = 1;
    src_q[1].push_back(8'h5A);
    repeat (20) cycle();
    chk("t5_no_grant", g_n - g0, 0);
    chk("t5_byte_pending", src_q[1].size(), 1);
    force_busy = 0;
    drain("t5");
    phase_chk("t5", g0, b0, d0, 1, 32'h1, 32'h5A);

    // 6: requester 2 sends three bytes while requester 0 waits
    g0 = g_n; b0 = b_n; d0 = d_n;
`ifdef UART_TX_ARB_LOCK_EN
    req_lock = 4'b0100;
`endif
    src_q[2].push_back(8'h61); src_q[2].push_back(8'h62); src_q[2].push_back(8'h63);
    src_q[0].push_back(8'h60);
    drain("t6");
`ifdef UART_TX_ARB_LOCK_EN
    phase_chk("t6", g0, b0, d0, 4, 32'h2220, 32'h61626360);
    req_lock = '0;
`else
    phase_chk("t6", g0, b0, d0, 4, 32'h2022, 32'h61606263);
`endif

    // 7: reset restores the pointer so requester 0 wins first again
    do_reset("t7");
    repeat (2) cycle();
    g0 = g_n; b0 = b_n; d0 = d_n;
    src_q[2].push_back(8'h72);
    src_q[0].push_back(8'h70);
    src_q[3].push_back(8'h73);
    src_q[1].push_back(8'h71);
    drain("t7");
    phase_chk("t7", g0, b0, d0, 4, 32'h0123, 32'h70717273);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
